// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared IF-stage types and constants
package if_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

  localparam int FETCH_BYTES = 8;
  localparam int INSTR_BYTES = 4;
  localparam int IF_PC_W     = 32;

  typedef struct packed {
    logic [31:0]        instr1;
    logic [31:0]        instr2;
    logic [IF_PC_W-1:0] pc;
    logic               valid1;
    logic               valid2;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch unit control, memory and IF/ID bundle
interface fetch_pc_unit_if #(
  parameter int PC_W = 32
);

  logic            stall_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic [31:0]     instruction1_i;
  logic [31:0]     instruction2_i;
  logic [PC_W-1:0] program_counter_o;
  logic [31:0]     if_id_instr1_o;
  logic [31:0]     if_id_instr2_o;
  logic [PC_W-1:0] if_id_pc_o;
  logic            if_id_valid1_o;
  logic            if_id_valid2_o;
  logic            halted_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, instruction1_i, instruction2_i,
    input  program_counter_o, if_id_instr1_o, if_id_instr2_o, if_id_pc_o,
    input  if_id_valid1_o, if_id_valid2_o, halted_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, instruction1_i, instruction2_i,
    output program_counter_o, if_id_instr1_o, if_id_instr2_o, if_id_pc_o,
    output if_id_valid1_o, if_id_valid2_o, halted_o
  );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush and hold
module if_id_reg
  import if_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [31:0]     instr1_i,
  input  logic [31:0]     instr2_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            valid2_i,
  output if_id_t          bundle_o
);

  if_id_t bundle_d;
  if_id_t bundle_q;

  // Flush only drops the valids; payload fields keep their last value.
  always_comb begin
    bundle_d = bundle_q;
    if (load_i) begin
      bundle_d.instr1 = instr1_i;
      bundle_d.instr2 = instr2_i;
      bundle_d.pc     = IF_PC_W'(pc_i);
      bundle_d.valid1 = 1'b1;
      bundle_d.valid2 = valid2_i;
    end else if (flush_i) begin
      bundle_d.valid1 = 1'b0;
      bundle_d.valid2 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= '0;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign bundle_o = bundle_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage program counter, fetch FSM and IF/ID capture
module fetch_pc_unit
  import if_pkg::*;
#(
  parameter int IMEM_BYTES = 128,
  parameter int RESET_PC   = 0,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            btnc_i,
  fetch_pc_unit_if.slave  bus
);

  if_state_e       state_d;
  if_state_e       state_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] pc_plus_fetch;
  logic            pc_in_range;
  logic            slot2_in_range;
  logic            load;
  logic            flush;
  logic            halted;
  if_id_t          if_id;

  assign redirect_target = bus.redirect_pc_i & ~PC_W'(INSTR_BYTES - 1);
  assign pc_plus_fetch   = pc_q + PC_W'(FETCH_BYTES);
  // Range checks use the registered PC so the halt decision precedes any increment.
  assign pc_in_range     = pc_q < PC_W'(IMEM_BYTES);
  assign slot2_in_range  = pc_plus_fetch <= PC_W'(IMEM_BYTES);

  always_ff @(posedge clk or negedge btnc_i) begin
    if (!btnc_i) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (bus.redirect_i) pc_d = redirect_target;
      end
      ST_RUN: begin
        if (bus.redirect_i) begin
          pc_d = redirect_target;
        end else if (!bus.stall_i) begin
          if (pc_in_range) pc_d = pc_plus_fetch;
          else             state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.redirect_i) begin
          pc_d    = redirect_target;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    load   = 1'b0;
    flush  = 1'b0;
    halted = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.redirect_i) begin
          flush = 1'b1;
        end else if (!bus.stall_i) begin
          load  = pc_in_range;
          flush = !pc_in_range;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        flush  = 1'b1;
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  if_id_reg #(
    .PC_W(PC_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (btnc_i),
    .load_i   (load),
    .flush_i  (flush),
    .instr1_i (bus.instruction1_i),
    .instr2_i (bus.instruction2_i),
    .pc_i     (pc_q),
    .valid2_i (slot2_in_range),
    .bundle_o (if_id)
  );

  assign bus.program_counter_o = pc_q;
  assign bus.if_id_instr1_o    = if_id.instr1;
  assign bus.if_id_instr2_o    = if_id.instr2;
  assign bus.if_id_pc_o        = PC_W'(if_id.pc);
  assign bus.if_id_valid1_o    = if_id.valid1;
  assign bus.if_id_valid2_o    = if_id.valid2;
  assign bus.halted_o          = halted;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed bench with cycle model for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam int IMEM = 128;

  logic clk = 1'b0;
  logic btnc_i = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  fetch_pc_unit_if #(.PC_W(32)) bus ();

  fetch_pc_unit #(
    .IMEM_BYTES(IMEM),
    .RESET_PC  (0),
    .PC_W      (32)
  ) dut (
    .clk    (clk),
    .btnc_i (btnc_i),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= IMEM)   return 32'h0;
    if (a == 32'd0)  return 32'h00011020;
    if (a == 32'd4)  return 32'h00441822;
    return 32'hA000_0000 | a;
  endfunction

  assign bus.instruction1_i = mem_word(bus.program_counter_o);
  assign bus.instruction2_i = mem_word(bus.program_counter_o + 32'd4);

  // Reference model: tracks what fetch must have produced, from the bench's own memory.
  int unsigned m_pc = 0;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  bit          m_v1 = 1'b0;
  bit          m_v2 = 1'b0;
  int unsigned m_ipc = 0;
  logic [31:0] m_i1 = '0;
  logic [31:0] m_i2 = '0;

  always @(posedge clk or negedge btnc_i) begin
    if (!btnc_i) begin
      m_pc <= 0; m_boot <= 1'b1; m_halt <= 1'b0;
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_ipc <= 0; m_i1 <= '0; m_i2 <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      if (bus.redirect_i) m_pc <= (bus.redirect_pc_i / 4) * 4;
    end else if (m_halt) begin
      if (bus.redirect_i) begin
        m_halt <= 1'b0;
        m_pc   <= (bus.redirect_pc_i / 4) * 4;
      end
    end else if (bus.redirect_i) begin
      m_pc <= (bus.redirect_pc_i / 4) * 4;
      m_v1 <= 1'b0; m_v2 <= 1'b0;
    end else if (!bus.stall_i) begin
      if (m_pc < IMEM) begin
        m_ipc <= m_pc;
        m_i1  <= mem_word(m_pc);
        m_i2  <= mem_word(m_pc + 4);
        m_v1  <= 1'b1;
        m_v2  <= (m_pc + 8 <= IMEM);
        m_pc  <= m_pc + 8;
      end else begin
        m_v1 <= 1'b0; m_v2 <= 1'b0; m_halt <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (bus.program_counter_o !== m_pc || bus.halted_o !== m_halt ||
        bus.if_id_valid1_o !== m_v1 || bus.if_id_valid2_o !== m_v2 ||
        bus.if_id_pc_o !== m_ipc || bus.if_id_instr1_o !== m_i1 ||
        bus.if_id_instr2_o !== m_i2) begin
      miscompares++;
      $display("FAIL model t=%0t: got pc=%h ifpc=%h i1=%h i2=%h v=%b%b h=%b want pc=%h ifpc=%h i1=%h i2=%h v=%b%b h=%b",
               $time, bus.program_counter_o, bus.if_id_pc_o, bus.if_id_instr1_o, bus.if_id_instr2_o,
               bus.if_id_valid1_o, bus.if_id_valid2_o, bus.halted_o,
               m_pc, m_ipc, m_i1, m_i2, m_v1, m_v2, m_halt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [31:0] pc, input logic [31:0] ifpc,
                           input logic v1, input logic v2, input logic h);
    chk({name, ".pc"},     bus.program_counter_o, pc);
    chk({name, ".ifpc"},   bus.if_id_pc_o, ifpc);
    chk({name, ".valid1"}, 32'(bus.if_id_valid1_o), 32'(v1));
    chk({name, ".valid2"}, 32'(bus.if_id_valid2_o), 32'(v2));
    chk({name, ".halted"}, 32'(bus.halted_o), 32'(h));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] tgt);
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = tgt;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0);
    btnc_i = 1'b0;
    tick(3);
    chk_state("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    btnc_i = 1'b1;

    tick();
    chk_state("boot", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("first", 32'd8, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("first.instr1", bus.if_id_instr1_o, 32'h00011020);
    chk("first.instr2", bus.if_id_instr2_o, 32'h00441822);

    tick();
    chk_state("run16", 32'd16, 32'd8, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0);
    tick(3);
    chk_state("stall", 32'd16, 32'd8, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_state("unstall", 32'd24, 32'd16, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("run32", 32'd32, 32'd24, 1'b1, 1'b1, 1'b0);

    // Redirect with stall: redirect wins; low bits of the target are dropped.
    drive(1'b1, 1'b1, 32'd30);
    tick();
    chk_state("redir28", 32'd28, 32'd24, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_state("odd_pair", 32'd36, 32'd28, 1'b1, 1'b1, 1'b0);
    chk("odd_pair.instr2", bus.if_id_instr2_o, 32'hA000_0020);

    drive(1'b0, 1'b1, 32'd120);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_state("last_full", 32'd128, 32'd120, 1'b1, 1'b1, 1'b0);
    tick();
    chk_state("halt128", 32'd128, 32'd120, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b1, 32'd124);
    tick();
    chk_state("halt_redir", 32'd124, 32'd120, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk_state("half_pair", 32'd132, 32'd124, 1'b1, 1'b0, 1'b0);
    tick();
    chk_state("halt132", 32'd132, 32'd124, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h0);
    tick(2);
    chk_state("halt_stall", 32'd132, 32'd124, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'd0);
    tick();
    chk_state("unhalt", 32'd0, 32'd124, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    tick(3);
    chk_state("rerun", 32'd24, 32'd16, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 btnc_i = 1'b0;
    #1;
    chk_state("async_rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    btnc_i = 1'b1;
    tick();
    chk_state("reboot", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_state("refetch", 32'd8, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("refetch.instr1", bus.if_id_instr1_o, 32'h00011020);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Upstream/downstream wrapper of the dual-issue instruction memory in the IF stage.
- Owns the program counter that drives the memory's byte address.
- Advances the PC by 8 bytes (two instructions) per cycle.
- Handles stall, branch/jump redirect and end-of-memory halt.
- Registers the returned instruction pair, its PC and per-slot valid bits into the IF/ID pipeline register consumed by ID.

Parameters:
IMEM_BYTES, 128, instruction memory size in bytes; fetch beyond this is illegal
RESET_PC, 0, byte address loaded into the PC on reset
PC_W, 32, program counter width

Ports:
clk  input  1  system clock, all state on rising edge
btnc_i  input  1  reset, asynchronous, active-low (same button that preloads instruction memory)
stall_i  input  1  hazard stall from ID; hold PC and IF/ID
redirect_i  input  1  taken branch/jump from ID/EX; flush and load redirect_pc_i
redirect_pc_i  input  PC_W  redirect target byte address, word aligned
instruction1_i  input  32  instruction at program_counter_o, from memory (combinational)
instruction2_i  input  32  instruction at program_counter_o+4, from memory
program_counter_o  output  PC_W  fetch address to instruction memory
if_id_instr1_o  output  32  registered slot-1 instruction
if_id_instr2_o  output  32  registered slot-2 instruction
if_id_pc_o  output  PC_W  registered PC of slot 1 (slot 2 = +4)
if_id_valid1_o  output  1  slot 1 holds a real instruction
if_id_valid2_o  output  1  slot 2 holds a real instruction
halted_o  output  1  fetch stopped at end of memory

Behaviour:
- Reset (btnc_i=0, async):
  - PC=RESET_PC; state=BOOT.
  - All if_id_* outputs 0; halted_o=0.
  - Held for the whole low period, independent of clk.
- FSM states:
  - BOOT: one cycle after reset release. The memory preload completes here. No capture, valids stay 0, PC held. The next edge goes to RUN; a redirect in BOOT loads the PC and still goes to RUN.
  - RUN: priority per edge is redirect > stall > advance.
    - redirect_i=1: PC<=redirect_pc_i with bits[1:0] forced to 0. Both valids <= 0 (flush); instr/pc regs hold. Stay RUN.
    - stall_i=1 (no redirect): PC and all IF/ID regs hold their values, valids included.
    - advance with PC < IMEM_BYTES:
      - IF/ID captures instruction1_i, instruction2_i and PC.
      - valid1<=1; valid2<=(PC+8 <= IMEM_BYTES).
      - PC<=PC+8.
    - advance with PC >= IMEM_BYTES: valids<=0, state<=HALT, PC held.
  - HALT: halted_o=1, valids 0, PC held.
    - stall_i is ignored.
    - redirect_i loads the PC, clears halted_o and returns to RUN on the same edge.
- Latency: PC to IF/ID is 1 cycle. After a redirect there is exactly one bubble cycle; the target pair appears in IF/ID on the second edge after redirect is sampled.
- Odd-word targets (e.g. 28): legal. The pair fetched is 28/32, with no pair alignment.
- Arithmetic is PC_W-bit unsigned. The halt check precedes the increment, so the PC never wraps.
- Valids are evaluated on the registered PC, not the incoming next PC.

Decomposition:
- Shared if_pkg holds:
  - state encoding (BOOT/RUN/HALT)
  - FETCH_BYTES=8 and INSTR_BYTES=4
  - an IF/ID bundle typedef (instr1, instr2, pc, valid1, valid2) for reuse by the ID stage.
- One natural sub-module, if_id_reg: the capture/hold/flush register bank, controlled by load/flush strobes from the FSM.

Test Plan:
1. Memory model holds 0x00011020 at byte 0 and 0x00441822 at byte 4; release btnc_i.
   - BOOT cycle: PC=0, valids 0.
   - Next edge: if_id_pc=0, instr1=0x00011020, instr2=0x00441822, both valid, PC=8.
2. Free run, 4 edges, no stall/redirect -> program_counter_o is 8,16,24,32 and if_id_pc_o is 0,8,16,24.
3. At PC=16, stall_i=1 for 3 edges -> PC stays 16 and IF/ID unchanged; stall drops -> next edge if_id_pc=16, PC=24.
4. redirect_i=1 with redirect_pc_i=28 and stall_i=1 in the same cycle -> redirect wins. Next edge: PC=28, valids 0. Following edge: if_id_pc=28, both valid.
5. Redirect to 124 (IMEM_BYTES=128):
   - Next fetch: if_id_pc=124, valid1=1, valid2=0, PC=132.
   - Next edge: HALT, halted_o=1, valids 0.
   - stall_i=1 in HALT has no effect.
   - redirect to 0 -> halted_o=0 and PC=0 on that edge.
6. btnc_i driven low mid-run between clock edges -> PC=0, valids 0 and halted_o=0 immediately. After release, one BOOT cycle, then the pair at 0 is captured.
